// File: rtl/conv_mac_seq.sv
// conv_mac_seq: sliding-window 1-D convolution MAC fed by a registered filter ROM.
// Define RELU_EN to clamp each output at zero (max(acc, 0)); timing is unchanged.
module conv_mac_seq #(
  parameter int N = 43,
  parameter int M = 16,
  parameter int T = 32,
  parameter int A = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] s_data_x,
  input  logic         s_valid_x,
  output logic         s_ready_x,
  output logic [A-1:0] fmem_addr,
  input  logic [T-1:0] fmem_z,
  output logic [T-1:0] m_data_y,
  output logic         m_valid_y,
  input  logic         m_ready_y
);
  localparam int NO = N - M + 1;
  localparam int OW = $clog2(NO + 1);
  typedef enum logic [1:0] {FILL, COMP, OUT, SHIFT} state_t;
  state_t r_state, w_next;
  logic [T-1:0] r_w [M];
  logic [T-1:0] r_acc, r_y, w_prod, w_sum, w_res;
  logic [A:0] r_fill, r_c;
  logic [OW-1:0] r_out;
  logic [A-1:0] w_idx;
  logic w_acc_x, w_acc_y, w_last;
  assign w_acc_x = s_valid_x && s_ready_x;
  assign w_acc_y = m_valid_y && m_ready_y;
  assign w_last = r_out == OW'(NO - 1);
  // ROM data arriving in cycle c belongs to address c-1, so pair it with w[c-1]
  assign w_idx = A'(r_c - 1'b1);
  assign w_prod = fmem_z * r_w[w_idx];
  assign w_sum = r_acc + w_prod;
`ifdef RELU_EN
  assign w_res = w_sum[T-1] ? '0 : w_sum;
`else
  assign w_res = w_sum;
`endif
  assign m_data_y = r_y;
  always_ff @(posedge clk)
    if (reset) r_state <= FILL;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == FILL && w_acc_x && r_fill == (A+1)'(M - 1)) w_next = COMP;
    if (r_state == COMP && r_c == (A+1)'(M)) w_next = OUT;
    if (r_state == OUT && w_acc_y) w_next = w_last ? FILL : SHIFT;
    if (r_state == SHIFT && w_acc_x) w_next = COMP;
  end
  always_comb begin
    s_ready_x = r_state == FILL || r_state == SHIFT;
    m_valid_y = r_state == OUT;
    fmem_addr = r_state == COMP ? r_c[A-1:0] : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < M; i++) r_w[i] <= '0;
      r_acc <= '0;
      r_y <= '0;
      r_fill <= '0;
      r_c <= '0;
      r_out <= '0;
    end else begin
      if (w_acc_x) begin
        for (int i = 0; i < M - 1; i++) r_w[i] <= r_w[i+1];
        r_w[M-1] <= s_data_x;
      end
      if (r_state == FILL && w_acc_x) r_fill <= r_fill + 1'b1;
      r_c <= (r_state == COMP && r_c != (A+1)'(M)) ? r_c + 1'b1 : '0;
      if (r_state == COMP) r_acc <= r_c == '0 ? '0 : w_sum;
      if (r_state == COMP && r_c == (A+1)'(M)) r_y <= w_res;
      if (w_acc_y) begin
        r_out <= w_last ? '0 : r_out + 1'b1;
        if (w_last) r_fill <= '0;
      end
    end
  end
endmodule

// File: tb/tb_conv_mac_seq.sv
// tb_conv_mac_seq: randomized directed bench for conv_mac_seq against a plain-arithmetic convolution model.
module tb_conv_mac_seq;
  localparam int N = 43, M = 16, T = 32, A = 4, NO = N - M + 1;
  logic clk = 0, reset;
  logic [T-1:0] s_data_x, fmem_z, m_data_y;
  logic s_valid_x, s_ready_x, m_valid_y, m_ready_y;
  logic [A-1:0] fmem_addr;
  int taps [M];
  int xs [N];
  int exp_y [NO];
  int errors = 0, checks = 0;

  conv_mac_seq dut (
    .clk(clk), .reset(reset),
    .s_data_x(s_data_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .fmem_addr(fmem_addr), .fmem_z(fmem_z),
    .m_data_y(m_data_y), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) fmem_z <= taps[fmem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  function automatic void model();
    for (int j = 0; j < NO; j++) begin
      int s = 0;
      for (int k = 0; k < M; k++) s += taps[k] * xs[j + k];
`ifdef RELU_EN
      if (s < 0) s = 0;
`endif
      exp_y[j] = s;
    end
  endfunction

  task automatic rand_taps(input int mag);
    for (int k = 0; k < M; k++) taps[k] = $urandom_range(0, 2 * mag) - mag;
  endtask

  task automatic run_vec(input int vpct, input int rpct, input int stall_len, input bit chk_addr);
    int xi = 0, yi = 0, cyc = 0, last_acc = -100, k16 = -1, vcnt = 0;
    bit prev_v = 0, stall = 0;
    logic [31:0] held = '0;
    model();
    while (yi < NO && cyc < 4000) begin
      s_valid_x = xi < N && $urandom_range(1, 100) <= vpct;
      s_data_x = xi < N ? xs[xi] : 0;
      m_ready_y = stall_len > 0 ? vcnt >= stall_len : $urandom_range(1, 100) <= rpct;
      @(negedge clk);
      if (stall) begin
        chk("bp_hold_data", m_data_y, held);
        chk("bp_hold_valid", m_valid_y, 1'b1);
      end
      if (m_valid_y) chk("no_ready_in_out", s_ready_x, 1'b0);
      if (m_valid_y && !prev_v) chk("latency", cyc - last_acc, M + 2);
      if (chk_addr && k16 >= 0 && cyc - k16 >= 1 && cyc - k16 <= M)
        chk("fmem_addr", fmem_addr, cyc - k16 - 1);
      if (s_valid_x && s_ready_x) begin
        last_acc = cyc;
        xi++;
        if (xi == M) k16 = cyc;
      end
      if (m_valid_y && m_ready_y) begin
        chk($sformatf("y%0d", yi), m_data_y, exp_y[yi]);
        yi++;
      end
      stall = m_valid_y && !m_ready_y;
      held = m_data_y;
      prev_v = m_valid_y;
      vcnt = stall ? vcnt + 1 : 0;
      @(posedge clk); #1;
      cyc++;
    end
    chk("outputs_done", yi, NO);
    chk("samples_used", xi, N);
    s_valid_x = 0;
    m_ready_y = 1;
    @(negedge clk);
    chk("fill_after_last", s_ready_x, 1'b1);
    chk("idle_after_last", m_valid_y, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    reset = 1; s_valid_x = 0; s_data_x = 0; m_ready_y = 0;
    rand_taps(65536);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", s_ready_x, 1'b1);
    chk("rst_valid", m_valid_y, 1'b0);
    chk("rst_data", m_data_y, 0);
    chk("rst_addr", fmem_addr, 0);
    @(posedge clk); #1;
    reset = 0;
    // all-ones vector, no stalls: latency and address sweep
    for (int i = 0; i < N; i++) xs[i] = 1;
    run_vec(100, 100, 0, 1);
    // impulse at x[15] under random valid/ready gaps
    for (int i = 0; i < N; i++) xs[i] = 0;
    xs[15] = 1;
    run_vec(70, 60, 0, 0);
    // random data with every output held off for 10 cycles
    rand_taps(40000);
    for (int i = 0; i < N; i++) xs[i] = $urandom;
    run_vec(85, 100, 10, 0);
    // wrap-around: max positive samples against +-65536 taps
    for (int k = 0; k < M; k++) taps[k] = $urandom_range(0, 1) ? 65536 : -65536;
    for (int i = 0; i < N; i++) xs[i] = 32'h7FFFFFFF;
    run_vec(100, 100, 0, 0);
    // reset while the first window is being computed
    rand_taps(100000);
    n = 0;
    s_valid_x = 1;
    for (int c = 0; c < 100 && n < M; c++) begin
      s_data_x = $urandom;
      @(negedge clk);
      if (s_ready_x) n++;
      @(posedge clk); #1;
    end
    s_valid_x = 0;
    repeat (5) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("midrst_valid", m_valid_y, 1'b0);
    chk("midrst_ready", s_ready_x, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) xs[i] = $urandom;
    run_vec(100, 100, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
